serial_sub64: RTL and testbench

Bit-serial two's-complement subtractor for the y86-64 ALU datapath. It computes `diff = a - b` one bit per clock, LSB first, using a single full-adder slice fed with `~b` and an initial carry of 1. It produces the condition-code inputs ZF, SF and OF plus a borrow flag. It runs under a start/done handshake and is the subtract counterpart to the ALU's ripple adder, intended for area-constrained sequential builds.

---
 rtl/serial_sub64_if.sv | 29 ++
 rtl/serial_sub64.sv | 153 +++++++++++++++
 tb/tb_serial_sub64.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_sub64_if.sv
// serial_sub64_if
//   Handshake and data bundle for the bit-serial subtractor.
//   master : drives start/a/b, observes busy/done/diff/zf/sf/of/borrow
//   slave  : the subtractor side (consumes operands, produces results)
//   WIDTH  : operand/result width in bits
interface serial_sub64_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             zf;
  logic             sf;
  logic             of;
  logic             borrow;

  modport master (
    output start, a, b,
    input  busy, done, diff, zf, sf, of, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, zf, sf, of, borrow
  );
endinterface

// File: rtl/serial_sub64.sv
// serial_sub64
//   Bit-serial two's-complement subtractor: diff = a - b, one bit per clock,
//   LSB first, through a single full-adder slice fed with ~b and an initial
//   carry of 1. Produces ZF/SF/OF condition-code inputs and an unsigned
//   borrow flag. Runs IDLE -> RUN (WIDTH cycles) -> DONE (one cycle).
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   bus.start  request, sampled only in IDLE
//   bus.a/b    minuend/subtrahend, captured on the accepted-start edge
//   bus.busy   high while bits are being processed
//   bus.done   one-cycle pulse, results valid
//   bus.diff   a - b mod 2^WIDTH (holds until the next commit)
//   bus.zf/sf/of/borrow  zero, sign, signed overflow, unsigned a < b
module serial_sub64 #(
  parameter int WIDTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  serial_sub64_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Full-adder sum bit.
  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  // Full-adder carry: majority of the three inputs.
  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  // Subtraction overflows only when the operand signs differ and the
  // result sign disagrees with the minuend sign.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                   input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic                    carry;
  logic                    a_msb_p0;
  logic                    b_msb_p0;
  logic [WIDTH-1:0]        opa_p0;
  logic [WIDTH-1:0]        opb_p0;
  logic [WIDTH-1:0]        res_p1;
  logic                    busy_q;
  logic                    vld_p2;
  logic signed [WIDTH-1:0] diff_p2;
  logic                    zf_p2;
  logic                    sf_p2;
  logic                    of_p2;
  logic                    borrow_p2;

  logic                    sum_bit;
  logic                    carry_nxt;
  logic [WIDTH-1:0]        res_nxt;

  // Stage p0 -> p1: one full-adder slice on the current LSBs. The result
  // register fills from the MSB end so that after WIDTH shifts bit 0 of the
  // difference has arrived at the LSB.
  always_comb begin
    sum_bit   = fa_sum(opa_p0[0], opb_p0[0], carry);
    carry_nxt = fa_carry(opa_p0[0], opb_p0[0], carry);
    res_nxt   = {sum_bit, res_p1[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      a_msb_p0  <= 1'b0;
      b_msb_p0  <= 1'b0;
      opa_p0    <= '0;
      opb_p0    <= '0;
      res_p1    <= '0;
      busy_q    <= 1'b0;
      vld_p2    <= 1'b0;
      diff_p2   <= '0;
      zf_p2     <= 1'b0;
      sf_p2     <= 1'b0;
      of_p2     <= 1'b0;
      borrow_p2 <= 1'b0;
    end else begin
      vld_p2 <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            // Stage p0: capture operands; ~b with carry-in 1 gives a + ~b + 1.
            opa_p0   <= bus.a;
            opb_p0   <= ~bus.b;
            a_msb_p0 <= bus.a[WIDTH-1];
            b_msb_p0 <= bus.b[WIDTH-1];
            carry    <= 1'b1;
            cnt      <= '0;
            busy_q   <= 1'b1;
            state    <= RUN;
          end
        end

        RUN: begin
          // Stage p1: accumulate one result bit per edge.
          opa_p0 <= opa_p0 >> 1;
          opb_p0 <= opb_p0 >> 1;
          res_p1 <= res_nxt;
          carry  <= carry_nxt;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            // Stage p2: commit the full word and flags, including this bit.
            diff_p2   <= res_nxt;
            zf_p2     <= (res_nxt == '0);
            sf_p2     <= res_nxt[WIDTH-1];
            of_p2     <= sub_ovf(a_msb_p0, b_msb_p0, res_nxt[WIDTH-1]);
            // Carry-out of a + ~b + 1 is the "no borrow" indication.
            borrow_p2 <= ~carry_nxt;
            busy_q    <= 1'b0;
            vld_p2    <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          // A start held high here is not queued; it is seen again in IDLE.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = vld_p2;
  assign bus.diff   = diff_p2;
  assign bus.zf     = zf_p2;
  assign bus.sf     = sf_p2;
  assign bus.of     = of_p2;
  assign bus.borrow = borrow_p2;

endmodule

// File: tb/tb_serial_sub64.sv
module tb_serial_sub64;

  typedef struct packed {
    logic [63:0] diff;
    logic        zf;
    logic        sf;
    logic        of;
    logic        borrow;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_sub64_if #(.WIDTH(64)) b64 ();
  serial_sub64_if #(.WIDTH(4))  b4 ();

  serial_sub64 #(.WIDTH(64)) dut64 (.clk(clk), .rst(rst), .bus(b64.slave));
  serial_sub64 #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(b4.slave));

  int   checks   = 0;
  int   failures = 0;
  exp_t q64[$];
  exp_t q4[$];

  // Reference: exact integer arithmetic on sign-extended values.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input int w);
    exp_t r;
    logic [63:0] mask;
    logic [63:0] am;
    logic [63:0] bm;
    logic signed [65:0] sa, sb, sd, smax, smin;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am = a & mask;
    bm = b & mask;
    sa = $signed({2'b00, am});
    sb = $signed({2'b00, bm});
    if (am[w-1]) sa = sa - (66'sd1 <<< w);
    if (bm[w-1]) sb = sb - (66'sd1 <<< w);
    sd   = sa - sb;
    smax = (66'sd1 <<< (w - 1)) - 66'sd1;
    smin = -(66'sd1 <<< (w - 1));
    r.diff   = (am - bm) & mask;
    r.zf     = (r.diff == 64'd0);
    r.sf     = r.diff[w-1];
    r.of     = (sd > smax) || (sd < smin);
    r.borrow = (am < bm);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmp_result(input string pfx, input exp_t e, input logic [63:0] d,
                            input logic zf, input logic sf, input logic of, input logic bo);
    chk({pfx, "_diff"}, d, e.diff);
    chk({pfx, "_zf"}, zf, e.zf);
    chk({pfx, "_sf"}, sf, e.sf);
    chk({pfx, "_of"}, of, e.of);
    chk({pfx, "_borrow"}, bo, e.borrow);
  endtask

  // One 64-bit operation. If poke > 0, a stray start with a=b=1 is driven
  // on RUN edge number poke, and a/b are scrambled on every other RUN edge.
  task automatic op64(input logic [63:0] a, input logic [63:0] b, input int poke);
    int   n;
    exp_t e;
    @(negedge clk);
    b64.a = a; b64.b = b; b64.start = 1'b1;
    q64.push_back(model(a, b, 64));
    @(posedge clk); #1;
    chk("busy64_after_start", b64.busy, 1'b1);
    n = 0;
    while (b64.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      if (poke > 0 && n == poke - 1) begin
        b64.a = 64'd1; b64.b = 64'd1; b64.start = 1'b1;
      end else begin
        b64.start = 1'b0; b64.a = {$urandom, $urandom}; b64.b = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      n++;
      chk("busy_done_excl64", b64.busy & b64.done, 1'b0);
    end
    b64.start = 1'b0;
    chk("latency64", n, 64);
    if (q64.size() > 0) begin
      e = q64.pop_front();
      cmp_result("op64", e, b64.diff, b64.zf, b64.sf, b64.of, b64.borrow);
      chk("busy64_at_done", b64.busy, 1'b0);
      @(posedge clk); #1;
      chk("done64_one_cycle", b64.done, 1'b0);
      chk("diff64_hold", b64.diff, e.diff);
    end
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b);
    int   n;
    exp_t e;
    @(negedge clk);
    b4.a = a; b4.b = b; b4.start = 1'b1;
    q4.push_back(model({60'd0, a}, {60'd0, b}, 4));
    @(posedge clk); #1;
    n = 0;
    while (b4.done !== 1'b1 && n < 20) begin
      @(negedge clk);
      b4.start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk("latency4", n, 4);
    if (q4.size() > 0) begin
      e = q4.pop_front();
      cmp_result("op4", e, {60'd0, b4.diff}, b4.zf, b4.sf, b4.of, b4.borrow);
      @(posedge clk); #1;
      chk("done4_one_cycle", b4.done, 1'b0);
    end
  endtask

  initial begin
    int   n;
    logic seen;
    exp_t e;
    b64.start = 1'b0; b64.a = '0; b64.b = '0;
    b4.start  = 1'b0; b4.a  = '0; b4.b  = '0;
    rst = 1'b1;
    #1;
    chk("rst_busy", b64.busy, 1'b0);
    chk("rst_done", b64.done, 1'b0);
    chk("rst_diff", b64.diff, 64'd0);
    chk("rst_flags", {b64.zf, b64.sf, b64.of, b64.borrow}, 4'b0000);
    chk("rst4_state", {b4.busy, b4.done, b4.diff}, 6'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Directed 64-bit operations.
    op64(64'd5, 64'd3, 0);
    op64(64'd3, 64'd5, 0);
    op64(64'h8000_0000_0000_0000, 64'd1, 0);
    op64(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 0);
    op64(64'd0, 64'h8000_0000_0000_0000, 0);
    op64(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);

    // Start during RUN is ignored; result stays 10 - 4.
    op64(64'd10, 64'd4, 20);
    chk("ignored_start_diff", b64.diff, 64'd6);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    b64.a = 64'd7; b64.b = 64'd2; b64.start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk) b64.start = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("midrst_busy", b64.busy, 1'b0);
    chk("midrst_done", b64.done, 1'b0);
    chk("midrst_diff", b64.diff, 64'd0);
    chk("midrst_flags", {b64.zf, b64.sf, b64.of, b64.borrow}, 4'b0000);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (b64.done === 1'b1 || b64.busy === 1'b1) seen = 1'b1;
    end
    chk("no_activity_after_rst", seen, 1'b0);
    op64(64'd100, 64'd58, 0);

    // Start held high on the 4-bit instance: back-to-back operations.
    @(negedge clk);
    b4.a = 4'd3; b4.b = 4'd9; b4.start = 1'b1;
    q4.push_back(model(64'd3, 64'd9, 4));
    @(posedge clk); #1;
    @(negedge clk);
    b4.a = 4'd12; b4.b = 4'd5;
    q4.push_back(model(64'd12, 64'd5, 4));
    n = 0;
    while (b4.done !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("held_latency4", n, 4);
    if (q4.size() > 0) begin
      e = q4.pop_front();
      cmp_result("held1", e, {60'd0, b4.diff}, b4.zf, b4.sf, b4.of, b4.borrow);
    end
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (b4.done !== 1'b1 && n < 20);
    chk("held_throughput_gap", n, 6);
    if (q4.size() > 0) begin
      e = q4.pop_front();
      cmp_result("held2", e, {60'd0, b4.diff}, b4.zf, b4.sf, b4.of, b4.borrow);
    end
    @(negedge clk) b4.start = 1'b0;
    repeat (3) @(posedge clk);

    // Exhaustive 4-bit operand sweep.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        op4(4'(i), 4'(j));
      end
    end

    chk("q64_drained", q64.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
